// File: rtl/fetch_stage.sv
// rtl/fetch_stage.sv - MIPS IF stage and IF/ID register with stall/redirect/wait FSM.
// Optional perf counters are built only when FETCH_PERF_EN is defined.
module fetch_stage #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        stall,
  input  logic        redirect,
  input  logic [31:0] redirect_pc,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic [31:0] imem_rdata,
  input  logic        imem_valid,
  output logic [31:0] IRD,
  output logic [31:0] pcD,
  output logic        validD,
  output logic [5:0]  opcode,
  output logic [4:0]  rs,
  output logic [4:0]  rt,
  output logic [1:0]  fetch_state
`ifdef FETCH_PERF_EN
  ,
  output logic [31:0] perf_hold_cnt,
  output logic [31:0] perf_bubble_cnt
`endif
);

  typedef enum logic [1:0] {
    ST_RUN  = 2'd0,
    ST_WAIT = 2'd1,
    ST_HOLD = 2'd2
  } state_e;

  logic [31:0] pc_q, pc_d;
  logic [31:0] ird_q, ird_d;
  logic [31:0] pcd_q, pcd_d;
  logic        validd_q, validd_d;
  state_e      state_q, state_d;
  logic        hold_cyc;
  logic        bubble_cyc;
  logic [31:0] pc_plus4;

  assign pc_plus4 = pc_q + 32'd4;

  // Priority: redirect beats stall, stall beats a missing memory response.
  always_comb begin
    pc_d       = pc_q;
    ird_d      = ird_q;
    pcd_d      = pcd_q;
    validd_d   = validd_q;
    state_d    = state_q;
    hold_cyc   = 1'b0;
    bubble_cyc = 1'b0;
    if (redirect) begin
      pc_d       = redirect_pc & ~32'h3;
      ird_d      = 32'h0;
      pcd_d      = 32'h0;
      validd_d   = 1'b0;
      state_d    = ST_RUN;
      bubble_cyc = 1'b1;
    end else if (!stall) begin
      state_d  = ST_HOLD;
      hold_cyc = 1'b1;
    end else if (!imem_valid) begin
      ird_d      = 32'h0;
      pcd_d      = 32'h0;
      validd_d   = 1'b0;
      state_d    = ST_WAIT;
      bubble_cyc = 1'b1;
    end else begin
      ird_d    = imem_rdata;
      pcd_d    = pc_plus4;
      validd_d = 1'b1;
      pc_d     = pc_plus4;
      state_d  = ST_RUN;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pc_q     <= RESET_PC;
      ird_q    <= 32'h0;
      pcd_q    <= 32'h0;
      validd_q <= 1'b0;
      state_q  <= ST_RUN;
    end else begin
      pc_q     <= pc_d;
      ird_q    <= ird_d;
      pcd_q    <= pcd_d;
      validd_q <= validd_d;
      state_q  <= state_d;
    end
  end

  assign imem_req    = ~rst;
  assign imem_addr   = pc_q;
  assign IRD         = ird_q;
  assign pcD         = pcd_q;
  assign validD      = validd_q;
  assign opcode      = ird_q[31:26];
  assign rs          = ird_q[25:21];
  assign rt          = ird_q[20:16];
  assign fetch_state = state_q;

`ifdef FETCH_PERF_EN
  logic [31:0] hold_cnt_q, hold_cnt_d;
  logic [31:0] bubble_cnt_q, bubble_cnt_d;

  always_comb begin
    hold_cnt_d   = hold_cnt_q;
    bubble_cnt_d = bubble_cnt_q;
    if (hold_cyc && hold_cnt_q != 32'hFFFF_FFFF) hold_cnt_d = hold_cnt_q + 32'd1;
    if (bubble_cyc && bubble_cnt_q != 32'hFFFF_FFFF) bubble_cnt_d = bubble_cnt_q + 32'd1;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      hold_cnt_q   <= 32'h0;
      bubble_cnt_q <= 32'h0;
    end else begin
      hold_cnt_q   <= hold_cnt_d;
      bubble_cnt_q <= bubble_cnt_d;
    end
  end

  assign perf_hold_cnt   = hold_cnt_q;
  assign perf_bubble_cnt = bubble_cnt_q;
`else
  logic unused_perf;
  assign unused_perf = hold_cyc ^ bubble_cyc;
`endif

endmodule

// File: tb/tb_fetch_stage.sv
// tb/tb_fetch_stage.sv - directed self-checking bench for fetch_stage.
// Perf counter checks are compiled in only when FETCH_PERF_EN is defined.
module tb_fetch_stage;

  logic        clk;
  logic        rst;
  logic        stall;
  logic        redirect;
  logic [31:0] redirect_pc;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic [31:0] imem_rdata;
  logic        imem_valid;
  logic [31:0] IRD;
  logic [31:0] pcD;
  logic        validD;
  logic [5:0]  opcode;
  logic [4:0]  rs;
  logic [4:0]  rt;
  logic [1:0]  fetch_state;
`ifdef FETCH_PERF_EN
  logic [31:0] perf_hold_cnt;
  logic [31:0] perf_bubble_cnt;
`endif

  logic        force_en;
  logic [31:0] force_val;
  int          n_cmp;
  int          n_mis;

  fetch_stage #(.RESET_PC(32'h0000_0000)) dut (
    .clk         (clk),
    .rst         (rst),
    .stall       (stall),
    .redirect    (redirect),
    .redirect_pc (redirect_pc),
    .imem_req    (imem_req),
    .imem_addr   (imem_addr),
    .imem_rdata  (imem_rdata),
    .imem_valid  (imem_valid),
    .IRD         (IRD),
    .pcD         (pcD),
    .validD      (validD),
    .opcode      (opcode),
    .rs          (rs),
    .rt          (rt),
    .fetch_state (fetch_state)
`ifdef FETCH_PERF_EN
    ,
    .perf_hold_cnt   (perf_hold_cnt),
    .perf_bubble_cnt (perf_bubble_cnt)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Memory model: each word is its address plus 0x100 unless overridden.
  always_comb imem_rdata = force_en ? force_val : (imem_addr + 32'h100);

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_mis++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    n_cmp       = 0;
    n_mis       = 0;
    rst         = 1'b1;
    stall       = 1'b1;
    redirect    = 1'b0;
    redirect_pc = 32'h0;
    imem_valid  = 1'b1;
    force_en    = 1'b0;
    force_val   = 32'h0;

    step();
    step();
    chk("rst_ird", IRD, 32'h0);
    chk("rst_valid", {31'b0, validD}, 32'h0);
    chk("rst_req", {31'b0, imem_req}, 32'h0);
    chk("rst_addr", imem_addr, 32'h0);
    chk("rst_state", {30'b0, fetch_state}, 32'd0);
    rst = 1'b0;
    #1;
    chk("req_up", {31'b0, imem_req}, 32'h1);

    step();
    chk("run0_ird", IRD, 32'h100);
    chk("run0_pcd", pcD, 32'h4);
    chk("run0_valid", {31'b0, validD}, 32'h1);
    step();
    chk("run1_ird", IRD, 32'h104);
    chk("run1_pcd", pcD, 32'h8);
    step();
    chk("run2_ird", IRD, 32'h108);
    chk("run2_pcd", pcD, 32'hC);

    force_en  = 1'b1;
    force_val = 32'h8C22_0004;
    step();
    force_en = 1'b0;
    chk("hz_ird", IRD, 32'h8C22_0004);
    chk("hz_opcode", {26'b0, opcode}, 32'h23);
    chk("hz_rs", {27'b0, rs}, 32'h1);
    chk("hz_rt", {27'b0, rt}, 32'h2);
    stall = 1'b0;
    for (int i = 0; i < 2; i++) begin
      step();
      chk("hold_ird", IRD, 32'h8C22_0004);
      chk("hold_pcd", pcD, 32'h10);
      chk("hold_addr", imem_addr, 32'h10);
      chk("hold_state", {30'b0, fetch_state}, 32'd2);
    end
    stall = 1'b1;
    step();
    chk("resume_ird", IRD, 32'h110);
    chk("resume_pcd", pcD, 32'h14);
    chk("resume_state", {30'b0, fetch_state}, 32'd0);

    stall       = 1'b0;
    redirect    = 1'b1;
    redirect_pc = 32'h0000_0043;
    step();
    chk("redir_ird", IRD, 32'h0);
    chk("redir_valid", {31'b0, validD}, 32'h0);
    chk("redir_addr", imem_addr, 32'h40);
    chk("redir_state", {30'b0, fetch_state}, 32'd0);
    stall    = 1'b1;
    redirect = 1'b0;
    step();
    chk("redir_tgt_ird", IRD, 32'h140);
    chk("redir_tgt_pcd", pcD, 32'h44);

    redirect    = 1'b1;
    redirect_pc = 32'h20;
    step();
    redirect   = 1'b0;
    imem_valid = 1'b0;
    for (int i = 0; i < 3; i++) begin
      step();
      chk("wait_ird", IRD, 32'h0);
      chk("wait_state", {30'b0, fetch_state}, 32'd1);
      chk("wait_addr", imem_addr, 32'h20);
    end
    stall = 1'b0;
    step();
    chk("wait_hold_ird", IRD, 32'h0);
    chk("wait_hold_state", {30'b0, fetch_state}, 32'd2);
    stall      = 1'b1;
    imem_valid = 1'b1;
    step();
    chk("wait_done_ird", IRD, 32'h120);
    chk("wait_done_pcd", pcD, 32'h24);
    chk("wait_done_state", {30'b0, fetch_state}, 32'd0);

    force_en  = 1'b1;
    force_val = 32'h0;
    step();
    force_en = 1'b0;
    chk("zero_word_ird", IRD, 32'h0);
    chk("zero_word_valid", {31'b0, validD}, 32'h1);

    redirect    = 1'b1;
    redirect_pc = 32'hFFFF_FFFE;
    step();
    redirect = 1'b0;
    chk("wrap_addr0", imem_addr, 32'hFFFF_FFFC);
    step();
    chk("wrap_ird", IRD, 32'h0000_00FC);
    chk("wrap_pcd", pcD, 32'h0);
    chk("wrap_addr", imem_addr, 32'h0);
    step();
    chk("wrap_next_ird", IRD, 32'h100);
    #2;
    rst = 1'b1;
    #1;
    chk("arst_ird", IRD, 32'h0);
    chk("arst_req", {31'b0, imem_req}, 32'h0);
    chk("arst_valid", {31'b0, validD}, 32'h0);
    chk("arst_addr", imem_addr, 32'h0);

`ifdef FETCH_PERF_EN
    chk("perf_rst_hold", perf_hold_cnt, 32'h0);
    chk("perf_rst_bub", perf_bubble_cnt, 32'h0);
    step();
    rst   = 1'b0;
    stall = 1'b0;
    step();
    step();
    stall       = 1'b1;
    redirect    = 1'b1;
    redirect_pc = 32'h80;
    step();
    redirect   = 1'b0;
    imem_valid = 1'b0;
    step();
    step();
    step();
    imem_valid = 1'b1;
    step();
    chk("perf_hold", perf_hold_cnt, 32'd2);
    chk("perf_bubble", perf_bubble_cnt, 32'd4);
    chk("perf_ird", IRD, 32'h180);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

endmodule
